// File: rtl/simon_pkg.sv
// -----------------------------------------------------------------------------
// simon_pkg
// Shared definitions for the Simon sequence-game core:
//   - state_e         : game FSM state encodings
//   - LFSR_W/TAPS     : width and tap mask of the 16-bit Fibonacci LFSR
//                       (taps 16,14,13,11 -> bits 15,13,12,10)
//   - TICK_W          : width of the playback tick counter
//   - CNT_W           : width of the len/idx/score counters
//   - TIMEOUT_W/RELOAD: player-timeout counter width and reload value
//   - lfsr_next()     : one LFSR step
// -----------------------------------------------------------------------------
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADD      = 3'd1,
        SHOW_ON  = 3'd2,
        SHOW_OFF = 3'd3,
        PLAYER   = 3'd4,
        WIN      = 3'd5,
        LOSE     = 3'd6
    } state_e;

    localparam int                LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int TICK_W = 24;
    localparam int CNT_W  = 8;

    localparam int                   TIMEOUT_W      = 28;
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_RELOAD = 28'd100_000_000;

    // Shift toward the MSB, feedback (XOR of tapped bits) enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/simon_seq_lfsr.sv
// -----------------------------------------------------------------------------
// simon_seq_lfsr
// 16-bit Fibonacci LFSR used as the colour source for the game sequence.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset, loads SEED
//   step  - advance the LFSR by one position this cycle
//   value - current LFSR contents
// -----------------------------------------------------------------------------
module simon_seq_lfsr
    import simon_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/simon_seq_core.sv
// -----------------------------------------------------------------------------
// simon_seq_core
// Simon memory-game sequencer: grows a random channel sequence one step per
// round, plays it back on an LED, then checks the player's presses.
//
// Parameters:
//   NUM_CH    - number of buttons/LEDs (2, 4 or 8)
//   MAX_LEN   - sequence length that wins the game (1..255)
//   TICKS_ON  - cycles an LED is lit per playback step (>= 1)
//   TICKS_OFF - dark cycles between playback steps (>= 1)
//   SEED      - LFSR reset value (nonzero)
// Ports:
//   clk         - clock
//   reset       - synchronous active-high reset
//   start       - one-cycle game start pulse (accepted in IDLE, WIN, LOSE)
//   btn_pressed - one-cycle debounced press pulses, one bit per channel
//   led_en      - playback LED lit
//   led_ch      - channel being lit
//   player_turn - waiting for player input
//   score       - completed rounds
//   lose / win  - level outputs, held until start or reset
//
// Build option: define SIMON_TIMEOUT_EN to make PLAYER give up (LOSE) after
// TIMEOUT_RELOAD cycles without an accepted press. Without it PLAYER waits
// forever and no timeout counter exists.
// -----------------------------------------------------------------------------
module simon_seq_core
    import simon_pkg::*;
#(
    parameter  int                NUM_CH    = 4,
    parameter  int                MAX_LEN   = 32,
    parameter  int                TICKS_ON  = 10000000,
    parameter  int                TICKS_OFF = 5000000,
    parameter  logic [LFSR_W-1:0] SEED      = 16'hACE1,
    localparam int                CH_W      = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NUM_CH-1:0] btn_pressed,
    output logic              led_en,
    output logic [CH_W-1:0]   led_ch,
    output logic              player_turn,
    output logic [7:0]        score,
    output logic              lose,
    output logic              win
);

    localparam int                AW         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [TICK_W-1:0] ON_RELOAD  = TICK_W'(TICKS_ON - 1);
    localparam logic [TICK_W-1:0] OFF_RELOAD = TICK_W'(TICKS_OFF - 1);
    localparam logic [CNT_W-1:0]  LEN_MAX    = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    state_e            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  score_q, score_d;
`ifdef SIMON_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_q, to_d;
`endif

    logic [CH_W-1:0]   seq_q [MAX_LEN];
    logic [CH_W-1:0]   seq_cur;
    logic              seq_we;

    logic              lfsr_step;
    logic [LFSR_W-1:0] lfsr_val;
    logic              lfsr_unused;

    logic              btn_onehot;
    logic [CH_W-1:0]   btn_ch;

    function automatic logic [CH_W-1:0] btn_to_ch(input logic [NUM_CH-1:0] b);
        logic [CH_W-1:0] ch;
        ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (b[i]) begin
                ch = CH_W'(i);
            end
        end
        return ch;
    endfunction

    simon_seq_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (lfsr_step),
        .value (lfsr_val)
    );

    // Only the low CH_W bits pick a channel; the rest only feed the shift.
    assign lfsr_unused = ^lfsr_val[LFSR_W-1:CH_W];

    assign seq_cur    = seq_q[idx_q[AW-1:0]];
    assign btn_onehot = (btn_pressed != '0) &&
                        ((btn_pressed & (btn_pressed - NUM_CH'(1))) == '0);
    assign btn_ch     = btn_to_ch(btn_pressed);

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        len_d     = len_q;
        idx_d     = idx_q;
        score_d   = score_q;
        seq_we    = 1'b0;
        lfsr_step = 1'b0;
`ifdef SIMON_TIMEOUT_EN
        to_d      = to_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = '0;
                    score_d = '0;
                    state_d = ADD;
                end else begin
                    // Held on the start cycle, so a start straight out of
                    // reset makes SEED's low bits the first colour.
                    lfsr_step = 1'b1;
                end
            end

            ADD: begin
                lfsr_step = 1'b1;
                seq_we    = 1'b1;
                len_d     = len_q + CNT_ONE;
                idx_d     = '0;
                state_d   = SHOW_ON;
            end

            SHOW_ON: begin
                if (tick_q == '0) begin
                    state_d = SHOW_OFF;
                end else begin
                    tick_d = tick_q - TICK_W'(1);
                end
            end

            SHOW_OFF: begin
                if (tick_q == '0) begin
                    if (idx_q + CNT_ONE < len_q) begin
                        idx_d   = idx_q + CNT_ONE;
                        state_d = SHOW_ON;
                    end else begin
                        idx_d   = '0;
                        state_d = PLAYER;
                    end
                end else begin
                    tick_d = tick_q - TICK_W'(1);
                end
            end

            PLAYER: begin
                if (btn_pressed == '0) begin
`ifdef SIMON_TIMEOUT_EN
                    if (to_q == '0) begin
                        state_d = LOSE;
                    end else begin
                        to_d = to_q - TIMEOUT_W'(1);
                    end
`endif
                end else if (btn_onehot && (btn_ch == seq_cur)) begin
                    idx_d = idx_q + CNT_ONE;
`ifdef SIMON_TIMEOUT_EN
                    to_d  = TIMEOUT_RELOAD;
`endif
                    if (idx_q + CNT_ONE == len_q) begin
                        score_d = len_q;
                        state_d = (len_q == LEN_MAX) ? WIN : ADD;
                    end
                end else begin
                    // Wrong channel or several buttons at once.
                    state_d = LOSE;
                end
            end

            WIN, LOSE: begin
                if (start) begin
                    len_d   = '0;
                    score_d = '0;
                    state_d = ADD;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // No state loops back to itself through a transition, so a state
        // change is exactly a state entry.
        if (state_d != state_q) begin
            if (state_d == SHOW_ON) begin
                tick_d = ON_RELOAD;
            end else if (state_d == SHOW_OFF) begin
                tick_d = OFF_RELOAD;
            end else begin
                tick_d = '0;
            end
`ifdef SIMON_TIMEOUT_EN
            if (state_d == PLAYER) begin
                to_d = TIMEOUT_RELOAD;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            score_q <= '0;
`ifdef SIMON_TIMEOUT_EN
            to_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            score_q <= score_d;
`ifdef SIMON_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end

    // Sequence store carries no reset; only entries below len are ever read.
    always_ff @(posedge clk) begin
        if (seq_we) begin
            seq_q[len_q[AW-1:0]] <= lfsr_val[CH_W-1:0];
        end
    end

    assign led_en      = (state_q == SHOW_ON);
    assign led_ch      = (state_q == SHOW_ON) ? seq_cur : '0;
    assign player_turn = (state_q == PLAYER);
    assign score       = score_q;
    assign lose        = (state_q == LOSE);
    assign win         = (state_q == WIN);

endmodule

// File: tb/tb_simon_seq_core.sv
module tb_simon_seq_core;

    localparam int NUM_CH    = 4;
    localparam int MAX_LEN   = 4;
    localparam int TICKS_ON  = 3;
    localparam int TICKS_OFF = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] btn_pressed;
    logic       led_en;
    logic [1:0] led_ch;
    logic       player_turn;
    logic [7:0] score;
    logic       lose;
    logic       win;

    simon_seq_core #(
        .NUM_CH    (NUM_CH),
        .MAX_LEN   (MAX_LEN),
        .TICKS_ON  (TICKS_ON),
        .TICKS_OFF (TICKS_OFF),
        .SEED      (SEED)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .btn_pressed (btn_pressed),
        .led_en      (led_en),
        .led_ch      (led_ch),
        .player_turn (player_turn),
        .score       (score),
        .lose        (lose),
        .win         (win)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Playback monitor: records the channel at each LED rise and the length
    // of each lit run; a reset abandons any run in progress.
    logic       prev_en  = 1'b0;
    int         run      = 0;
    int         fall_cyc = 0;
    logic [1:0] obs_ch[$];
    int         obs_len[$];

    always @(negedge clk) begin
        if (reset) begin
            prev_en <= 1'b0;
            run     <= 0;
        end else begin
            prev_en <= led_en;
            if (led_en && !prev_en) begin
                obs_ch.push_back(led_ch);
                run <= 1;
            end else if (led_en) begin
                run <= run + 1;
            end else if (prev_en) begin
                obs_len.push_back(run);
                fall_cyc <= cyc;
            end
        end
    end

    // Reference model: LFSR, game sequence and expected playback queue.
    logic [15:0] lfsr_m;
    logic [1:0]  seq_m[$];
    logic [1:0]  exp_q[$];

    function automatic logic [15:0] m_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    task automatic add_round();
        seq_m.push_back(lfsr_m[1:0]);
        lfsr_m = m_next(lfsr_m);
        exp_q.delete();
        foreach (seq_m[i]) exp_q.push_back(seq_m[i]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        start       = 1'b0;
        btn_pressed = '0;
        step();
        reset = 1'b0;
        obs_ch.delete();
        obs_len.delete();
        exp_q.delete();
        seq_m.delete();
        lfsr_m = SEED;
        chk("rst_led_en",      32'(led_en),      32'd0);
        chk("rst_led_ch",      32'(led_ch),      32'd0);
        chk("rst_player_turn", 32'(player_turn), 32'd0);
        chk("rst_score",       32'(score),       32'd0);
        chk("rst_win",         32'(win),         32'd0);
        chk("rst_lose",        32'(lose),        32'd0);
    endtask

    task automatic start_game(input int idle_n);
        repeat (idle_n) begin
            step();
            lfsr_m = m_next(lfsr_m);
        end
        seq_m.delete();
        obs_ch.delete();
        obs_len.delete();
        add_round();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_score", 32'(score),       32'd0);
        chk("start_win",   32'(win),         32'd0);
        chk("start_lose",  32'(lose),        32'd0);
        chk("start_turn",  32'(player_turn), 32'd0);
    endtask

    task automatic wait_turn(input bit noise);
        int         n = 0;
        int         k;
        logic [1:0] e;
        while (!player_turn && n < 200) begin
            btn_pressed = noise ? 4'($urandom_range(0, 15)) : 4'd0;
            step();
            n++;
        end
        btn_pressed = '0;
        if (!player_turn) begin
            checks++;
            errors++;
            $display("FAIL wait_turn: player_turn still 0 after %0d cycles", n);
            return;
        end
        chk("turn_delay", 32'(cyc - fall_cyc), 32'(TICKS_OFF));
        chk("pulse_count", 32'(obs_ch.size()), 32'(exp_q.size()));
        k = 0;
        while (exp_q.size() > 0 && obs_ch.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("led_ch[%0d]", k), 32'(obs_ch.pop_front()), 32'(e));
            if (obs_len.size() > 0)
                chk($sformatf("led_len[%0d]", k), 32'(obs_len.pop_front()), 32'(TICKS_ON));
            k++;
        end
        exp_q.delete();
        obs_ch.delete();
        obs_len.delete();
    endtask

    task automatic press(input logic [3:0] b);
        btn_pressed = b;
        step();
        btn_pressed = '0;
    endtask

    task automatic play_round(input int r);
        for (int i = 0; i < r; i++) begin
            if (i == r - 1 && r < MAX_LEN) add_round();
            press(oh(seq_m[i]));
            if (i < r - 1) chk("mid_round_turn", 32'(player_turn), 32'd1);
        end
        chk("round_score", 32'(score), 32'(r));
        chk("round_win",   32'(win),   32'(r == MAX_LEN));
        chk("round_turn",  32'(player_turn), 32'd0);
    endtask

    // mode 0: raw pattern, 1: correct channel, 2: channel+1, 3: channel+3
    typedef struct {
        int         mode;
        logic [3:0] raw;
        logic       exp_turn;
        logic       exp_lose;
        logic [7:0] exp_score;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int         n;
        logic [3:0] b;

        vecs[0] = '{0, 4'b0000, 1'b1, 1'b0, 8'd0};
        vecs[1] = '{1, 4'b0000, 1'b0, 1'b0, 8'd1};
        vecs[2] = '{2, 4'b0000, 1'b0, 1'b1, 8'd0};
        vecs[3] = '{3, 4'b0000, 1'b0, 1'b1, 8'd0};
        vecs[4] = '{0, 4'b0011, 1'b0, 1'b1, 8'd0};
        vecs[5] = '{0, 4'b1111, 1'b0, 1'b1, 8'd0};

        reset       = 1'b1;
        start       = 1'b0;
        btn_pressed = '0;

        // Single presses in round 1, each from a fresh game.
        foreach (vecs[v]) begin
            do_reset();
            start_game(0);
            wait_turn(1'b0);
            case (vecs[v].mode)
                1:       b = oh(seq_m[0]);
                2:       b = oh(seq_m[0] + 2'd1);
                3:       b = oh(seq_m[0] + 2'd3);
                default: b = vecs[v].raw;
            endcase
            press(b);
            chk($sformatf("vec%0d_turn", v),  32'(player_turn), 32'(vecs[v].exp_turn));
            chk($sformatf("vec%0d_lose", v),  32'(lose),        32'(vecs[v].exp_lose));
            chk($sformatf("vec%0d_score", v), 32'(score),       32'(vecs[v].exp_score));
            chk($sformatf("vec%0d_win", v),   32'(win),         32'd0);
        end

        // Full game after idling in IDLE, with presses during playback.
        do_reset();
        start_game(5);
        for (int r = 1; r <= MAX_LEN; r++) begin
            wait_turn(1'b1);
            play_round(r);
        end
        repeat (3) step();
        chk("win_held",       32'(win),         32'd1);
        chk("win_led_en",     32'(led_en),      32'd0);
        chk("win_score_held", 32'(score),       32'(MAX_LEN));
        press(4'b0001);
        chk("win_ignores_btn", 32'(win),        32'd1);
        start_game(0);
        wait_turn(1'b0);
        chk("new_game_score", 32'(score), 32'd0);

        // Wrong press in round 2.
        do_reset();
        start_game(0);
        wait_turn(1'b0);
        play_round(1);
        wait_turn(1'b0);
        press(oh(seq_m[0]));
        chk("r2_first_turn", 32'(player_turn), 32'd1);
        press(oh(seq_m[1] + 2'd1));
        chk("r2_lose",  32'(lose),        32'd1);
        chk("r2_score", 32'(score),       32'd1);
        chk("r2_turn",  32'(player_turn), 32'd0);
        repeat (3) step();
        chk("lose_held", 32'(lose), 32'd1);
        start_game(0);
        wait_turn(1'b0);

        // Reset during SHOW_ON of round 3.
        do_reset();
        start_game(0);
        wait_turn(1'b0);
        play_round(1);
        wait_turn(1'b0);
        play_round(2);
        n = 0;
        while (!led_en && n < 50) begin
            step();
            n++;
        end
        chk("r3_show_on_reached", 32'(led_en), 32'd1);
        do_reset();
        start_game(0);
        wait_turn(1'b0);

`ifndef SIMON_TIMEOUT_EN
        repeat (3000) step();
        chk("no_timeout_turn", 32'(player_turn), 32'd1);
        chk("no_timeout_lose", 32'(lose),        32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
